// File: rtl/apb2nmi_bridge_if.sv
// APB4 responder signals plus NMI initiator signals for the APB-to-NMI bridge.
// slave is the bridge's view; master is the requester/memory-side view.
interface apb2nmi_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [2:0]            pprot;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [31:0]           pwdata;
  logic [3:0]            pstrb;
  logic                  pready;
  logic [31:0]           prdata;
  logic                  pslverr;
  logic                  nmi_valid_o;
  logic [ADDR_WIDTH-1:0] nmi_addr_o;
  logic [31:0]           nmi_wdata_o;
  logic [3:0]            nmi_wstrb_o;
  logic [31:0]           nmi_rdata_i;
  logic                  nmi_ready_i;

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  nmi_rdata_i, nmi_ready_i,
    output pready, prdata, pslverr,
    output nmi_valid_o, nmi_addr_o, nmi_wdata_o, nmi_wstrb_o
  );

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output nmi_rdata_i, nmi_ready_i,
    input  pready, prdata, pslverr,
    input  nmi_valid_o, nmi_addr_o, nmi_wdata_o, nmi_wstrb_o
  );
endinterface

// File: rtl/apb2nmi_bridge.sv
// APB4 responder issuing one NMI transaction per transfer; pready one cycle after NMI ready (min 3-cycle APB transfer).
// Backpressure: APB is stalled (pready=0) while NMI valid waits, bounded by TIMEOUT_CYCLES, then a bus error.
module apb2nmi_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  apb2nmi_bridge_if.slave  bus,
  output logic             timeout_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  pready_q;
  logic [31:0]           prdata_q;
  logic                  pslverr_q;
  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  unused_inputs;

  // Protection bits and byte offset never reach the NMI side.
  assign unused_inputs = ^{bus.pprot, bus.paddr[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.psel && bus.penable) begin
            // Access phase without a setup phase: reject without touching NMI.
            state     <= RESP;
            pready_q  <= 1'b1;
            prdata_q  <= '0;
            pslverr_q <= 1'b1;
          end else if (bus.psel) begin
            if (bus.pwrite && (bus.pstrb == 4'h0)) begin
              state     <= RESP;
              pready_q  <= 1'b1;
              prdata_q  <= '0;
              pslverr_q <= 1'b0;
            end else begin
              state    <= REQ;
              valid_q  <= 1'b1;
              wait_cnt <= '0;
              addr_q   <= {bus.paddr[ADDR_WIDTH-1:2], 2'b00};
              wdata_q  <= bus.pwdata;
              wstrb_q  <= bus.pwrite ? bus.pstrb : 4'h0;
            end
          end
        end
        REQ: begin
          // Ready is checked first so it wins in the final allowed cycle.
          if (bus.nmi_ready_i) begin
            state     <= RESP;
            valid_q   <= 1'b0;
            pready_q  <= 1'b1;
            prdata_q  <= (wstrb_q == 4'h0) ? bus.nmi_rdata_i : 32'h0;
            pslverr_q <= 1'b0;
          end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST)) begin
            state     <= RESP;
            valid_q   <= 1'b0;
            pready_q  <= 1'b1;
            prdata_q  <= '0;
            pslverr_q <= 1'b1;
            timeout_o <= 1'b1;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          // Response completes regardless of psel; a dropped psel just discards it.
          state    <= IDLE;
          pready_q <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          pready_q <= 1'b0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pready      = pready_q;
  assign bus.prdata      = prdata_q;
  assign bus.pslverr     = pslverr_q;
  assign bus.nmi_valid_o = valid_q;
  assign bus.nmi_addr_o  = addr_q;
  assign bus.nmi_wdata_o = wdata_q;
  assign bus.nmi_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_apb2nmi_bridge.sv
// Directed bench: dut_a (TIMEOUT_CYCLES=255) and dut_t (TIMEOUT_CYCLES=4) share one stimulus stream.
module tb_apb2nmi_bridge;

  logic clk;
  logic rst;
  logic timeout_a;
  logic timeout_t;
  int   checks = 0;
  int   errors = 0;

  apb2nmi_bridge_if #(.ADDR_WIDTH(32)) bus_a ();
  apb2nmi_bridge_if #(.ADDR_WIDTH(32)) bus_t ();

  apb2nmi_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(255)) dut_a (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus_a),
    .timeout_o (timeout_a)
  );

  apb2nmi_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut_t (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus_t),
    .timeout_o (timeout_t)
  );

  assign bus_t.paddr       = bus_a.paddr;
  assign bus_t.pprot       = bus_a.pprot;
  assign bus_t.psel        = bus_a.psel;
  assign bus_t.penable     = bus_a.penable;
  assign bus_t.pwrite      = bus_a.pwrite;
  assign bus_t.pwdata      = bus_a.pwdata;
  assign bus_t.pstrb       = bus_a.pstrb;
  assign bus_t.nmi_rdata_i = bus_a.nmi_rdata_i;
  assign bus_t.nmi_ready_i = bus_a.nmi_ready_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus_a.psel    = 1'b0;
    bus_a.penable = 1'b0;
    bus_a.pwrite  = 1'b0;
    bus_a.pstrb   = 4'h0;
  endtask

  task automatic test_reset();
    rst               = 1'b1;
    bus_a.paddr       = '0;
    bus_a.pprot       = 3'b000;
    bus_a.pwdata      = '0;
    bus_a.nmi_rdata_i = '0;
    bus_a.nmi_ready_i = 1'b0;
    idle_bus();
    tick();
    tick();
    checks++;
    if ({bus_a.pready, bus_a.pslverr, bus_a.nmi_valid_o, timeout_a} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 0000",
               {bus_a.pready, bus_a.pslverr, bus_a.nmi_valid_o, timeout_a});
    end
    checks++;
    if ({bus_a.prdata, bus_a.nmi_addr_o, bus_a.nmi_wdata_o, bus_a.nmi_wstrb_o} !== 100'h0) begin
      errors++;
      $display("FAIL reset_data got prdata=%h addr=%h wdata=%h wstrb=%h expected all 0",
               bus_a.prdata, bus_a.nmi_addr_o, bus_a.nmi_wdata_o, bus_a.nmi_wstrb_o);
    end
    checks++;
    if ({bus_t.pready, bus_t.nmi_valid_o, timeout_t} !== 3'b000) begin
      errors++;
      $display("FAIL reset_t got %b expected 000", {bus_t.pready, bus_t.nmi_valid_o, timeout_t});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    bus_a.psel  = 1'b1;
    bus_a.paddr = 32'h1000_0006;
    tick();  // T1
    bus_a.penable     = 1'b1;
    bus_a.nmi_ready_i = 1'b1;
    bus_a.nmi_rdata_i = 32'hDEAD_BEEF;
    checks++;
    if ({bus_a.nmi_valid_o, bus_a.pready} !== 2'b10) begin
      errors++;
      $display("FAIL read_t1_valid got valid,pready=%b expected 10", {bus_a.nmi_valid_o, bus_a.pready});
    end
    checks++;
    if (bus_a.nmi_addr_o !== 32'h1000_0004 || bus_a.nmi_wstrb_o !== 4'h0) begin
      errors++;
      $display("FAIL read_addr got addr=%h wstrb=%h expected 10000004/0",
               bus_a.nmi_addr_o, bus_a.nmi_wstrb_o);
    end
    tick();  // T2
    bus_a.nmi_ready_i = 1'b0;
    checks++;
    if ({bus_a.pready, bus_a.pslverr, bus_a.nmi_valid_o} !== 3'b100 || bus_a.prdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_resp got pready,pslverr,valid=%b prdata=%h expected 100/deadbeef",
               {bus_a.pready, bus_a.pslverr, bus_a.nmi_valid_o}, bus_a.prdata);
    end
    tick();  // T3
    idle_bus();
    checks++;
    if (bus_a.pready !== 1'b0) begin
      errors++;
      $display("FAIL read_done got pready=%b expected 0", bus_a.pready);
    end
    tick();
  endtask

  task automatic test_write_delayed();
    bus_a.psel   = 1'b1;
    bus_a.pwrite = 1'b1;
    bus_a.paddr  = 32'h2000_0010;
    bus_a.pwdata = 32'h1234_5678;
    bus_a.pstrb  = 4'b0011;
    for (int k = 1; k <= 6; k++) begin
      tick();
      bus_a.penable     = 1'b1;
      bus_a.nmi_ready_i = (k == 6);
      checks++;
      if ({bus_a.nmi_valid_o, bus_a.pready} !== 2'b10) begin
        errors++;
        $display("FAIL write_wait T%0d got valid,pready=%b expected 10", k, {bus_a.nmi_valid_o, bus_a.pready});
      end
      if (k == 1) begin
        checks++;
        if (bus_a.nmi_wstrb_o !== 4'b0011 || bus_a.nmi_wdata_o !== 32'h1234_5678 ||
            bus_a.nmi_addr_o !== 32'h2000_0010) begin
          errors++;
          $display("FAIL write_req got addr=%h wdata=%h wstrb=%b expected 20000010/12345678/0011",
                   bus_a.nmi_addr_o, bus_a.nmi_wdata_o, bus_a.nmi_wstrb_o);
        end
      end
    end
    tick();  // T7
    bus_a.nmi_ready_i = 1'b0;
    checks++;
    if ({bus_a.pready, bus_a.pslverr, bus_a.nmi_valid_o} !== 3'b100 || bus_a.prdata !== 32'h0) begin
      errors++;
      $display("FAIL write_resp got pready,pslverr,valid=%b prdata=%h expected 100/0",
               {bus_a.pready, bus_a.pslverr, bus_a.nmi_valid_o}, bus_a.prdata);
    end
    tick();  // T8
    idle_bus();
    checks++;
    if (bus_a.pready !== 1'b0) begin
      errors++;
      $display("FAIL write_done got pready=%b expected 0", bus_a.pready);
    end
    tick();
    tick();
  endtask

  task automatic test_ready_last_cycle();
    bus_a.psel  = 1'b1;
    bus_a.paddr = 32'h0000_0040;
    for (int k = 1; k <= 4; k++) begin
      tick();
      bus_a.penable     = 1'b1;
      bus_a.nmi_ready_i = (k == 4);
      bus_a.nmi_rdata_i = 32'hCAFE_0001;
      checks++;
      if (bus_t.nmi_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL last_ready_valid T%0d got %b expected 1", k, bus_t.nmi_valid_o);
      end
    end
    tick();  // T5
    bus_a.nmi_ready_i = 1'b0;
    checks++;
    if ({bus_t.pready, bus_t.pslverr, timeout_t} !== 3'b100 || bus_t.prdata !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL last_ready_resp got pready,pslverr,timeout=%b prdata=%h expected 100/cafe0001",
               {bus_t.pready, bus_t.pslverr, timeout_t}, bus_t.prdata);
    end
    tick();
    idle_bus();
    tick();
  endtask

  task automatic test_timeout();
    bus_a.psel  = 1'b1;
    bus_a.paddr = 32'h0000_0030;
    for (int k = 1; k <= 4; k++) begin
      tick();
      bus_a.penable = 1'b1;
      checks++;
      if ({bus_t.nmi_valid_o, timeout_t, bus_t.pready} !== 3'b100) begin
        errors++;
        $display("FAIL timeout_wait T%0d got valid,timeout,pready=%b expected 100",
                 k, {bus_t.nmi_valid_o, timeout_t, bus_t.pready});
      end
    end
    tick();  // T5
    checks++;
    if ({timeout_t, bus_t.pready, bus_t.pslverr, bus_t.nmi_valid_o} !== 4'b1110 || bus_t.prdata !== 32'h0) begin
      errors++;
      $display("FAIL timeout_resp got timeout,pready,pslverr,valid=%b prdata=%h expected 1110/0",
               {timeout_t, bus_t.pready, bus_t.pslverr, bus_t.nmi_valid_o}, bus_t.prdata);
    end
    tick();  // T6
    idle_bus();
    checks++;
    if ({timeout_t, bus_t.pready} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_pulse got timeout,pready=%b expected 00", {timeout_t, bus_t.pready});
    end
    checks++;
    if (bus_a.nmi_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL psel_drop_keeps_req got valid=%b expected 1", bus_a.nmi_valid_o);
    end
    bus_a.nmi_ready_i = 1'b1;
    tick();
    bus_a.nmi_ready_i = 1'b0;
    checks++;
    if ({bus_a.pready, bus_a.pslverr, bus_a.nmi_valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL psel_drop_resp got pready,pslverr,valid=%b expected 100",
               {bus_a.pready, bus_a.pslverr, bus_a.nmi_valid_o});
    end
    tick();
    tick();
  endtask

  task automatic test_zero_strobe();
    bus_a.psel   = 1'b1;
    bus_a.pwrite = 1'b1;
    bus_a.pstrb  = 4'h0;
    bus_a.paddr  = 32'h0000_0050;
    tick();  // T1
    bus_a.penable = 1'b1;
    checks++;
    if ({bus_a.pready, bus_a.pslverr, bus_a.nmi_valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL zero_strobe_a got pready,pslverr,valid=%b expected 100",
               {bus_a.pready, bus_a.pslverr, bus_a.nmi_valid_o});
    end
    checks++;
    if ({bus_t.pready, bus_t.pslverr, bus_t.nmi_valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL zero_strobe_t got pready,pslverr,valid=%b expected 100",
               {bus_t.pready, bus_t.pslverr, bus_t.nmi_valid_o});
    end
    tick();  // T2
    idle_bus();
    checks++;
    if ({bus_a.pready, bus_a.nmi_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL zero_strobe_done got pready,valid=%b expected 00", {bus_a.pready, bus_a.nmi_valid_o});
    end
    tick();
  endtask

  task automatic test_orphan();
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    bus_a.psel    = 1'b1;
    bus_a.penable = 1'b1;
    bus_a.paddr   = 32'h0000_0060;
    tick();
    checks++;
    if ({bus_a.pready, bus_a.pslverr, bus_a.nmi_valid_o} !== 3'b110 || bus_a.prdata !== 32'h0) begin
      errors++;
      $display("FAIL orphan_resp got pready,pslverr,valid=%b prdata=%h expected 110/0",
               {bus_a.pready, bus_a.pslverr, bus_a.nmi_valid_o}, bus_a.prdata);
    end
    idle_bus();
    tick();
    checks++;
    if ({bus_a.pready, bus_a.nmi_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL orphan_done got pready,valid=%b expected 00", {bus_a.pready, bus_a.nmi_valid_o});
    end
    tick();
  endtask

  task automatic test_reset_mid_req();
    bus_a.psel  = 1'b1;
    bus_a.paddr = 32'h0000_0070;
    for (int k = 1; k <= 3; k++) begin
      tick();
      bus_a.penable = 1'b1;
      checks++;
      if (bus_a.nmi_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL stall_valid T%0d got %b expected 1", k, bus_a.nmi_valid_o);
      end
      if (k == 3) rst = 1'b1;
    end
    tick();  // T4
    rst = 1'b0;
    idle_bus();
    checks++;
    if ({bus_a.nmi_valid_o, bus_a.pready, bus_t.nmi_valid_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_req got valid_a,pready_a,valid_t=%b expected 000",
               {bus_a.nmi_valid_o, bus_a.pready, bus_t.nmi_valid_o});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bus_a.psel  = 1'b1;
    bus_a.paddr = 32'h0000_0084;
    tick();  // T1
    bus_a.penable     = 1'b1;
    bus_a.nmi_ready_i = 1'b1;
    bus_a.nmi_rdata_i = 32'hA5A5_0001;
    tick();  // T2
    bus_a.nmi_ready_i = 1'b0;
    checks++;
    if (bus_a.pready !== 1'b1 || bus_a.prdata !== 32'hA5A5_0001 || bus_a.pslverr !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got pready=%b prdata=%h pslverr=%b expected 1/a5a50001/0",
               bus_a.pready, bus_a.prdata, bus_a.pslverr);
    end
    tick();  // T3: second setup in the IDLE cycle after RESP
    bus_a.penable = 1'b0;
    bus_a.paddr   = 32'h0000_0093;
    checks++;
    if (bus_a.pready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got pready=%b expected 0", bus_a.pready);
    end
    tick();  // T4
    bus_a.penable     = 1'b1;
    bus_a.nmi_ready_i = 1'b1;
    bus_a.nmi_rdata_i = 32'h5A5A_0002;
    checks++;
    if (bus_a.nmi_valid_o !== 1'b1 || bus_a.nmi_addr_o !== 32'h0000_0090) begin
      errors++;
      $display("FAIL b2b_second_req got valid=%b addr=%h expected 1/00000090",
               bus_a.nmi_valid_o, bus_a.nmi_addr_o);
    end
    tick();  // T5
    bus_a.nmi_ready_i = 1'b0;
    checks++;
    if (bus_a.pready !== 1'b1 || bus_a.prdata !== 32'h5A5A_0002) begin
      errors++;
      $display("FAIL b2b_second got pready=%b prdata=%h expected 1/5a5a0002", bus_a.pready, bus_a.prdata);
    end
    tick();
    idle_bus();
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_delayed();
    test_ready_last_cycle();
    test_timeout();
    test_zero_strobe();
    test_orphan();
    test_reset_mid_req();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
